// File: rtl/cacheline_adapter.sv
// Bridges 256-bit cache line fill/writeback requests to 4-beat 64-bit memory bursts.
// Define CACHELINE_ADAPTER_PERF_EN to add saturating read_lines/write_lines completion counters.
module cacheline_adapter #(
  parameter int s_line = 256,
  parameter int s_beat = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [31:0]       line_address,
  input  logic [s_line-1:0] line_wdata,
  output logic [s_line-1:0] line_rdata,
  output logic              line_resp,
  output logic              burst_read,
  output logic              burst_write,
  output logic [31:0]       burst_address,
  output logic [s_beat-1:0] burst_wdata,
  input  logic [s_beat-1:0] burst_rdata,
  input  logic              burst_resp
`ifdef CACHELINE_ADAPTER_PERF_EN
  ,
  output logic [31:0]       read_lines,
  output logic [31:0]       write_lines
`endif
);

  localparam int BEATS = s_line / s_beat;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                   state;
  logic [1:0]                   cnt;
  logic [31:0]                  addr;
  logic [BEATS-1:0][s_beat-1:0] rline;
  logic [BEATS-1:0][s_beat-1:0] wline;
  logic                         last_beat;

  assign last_beat = burst_resp && (cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      addr  <= '0;
      rline <= '0;
      wline <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Read wins when both requests arrive together.
          if (line_read) begin
            addr  <= line_address;
            cnt   <= '0;
            state <= READ;
          end else if (line_write) begin
            addr  <= line_address;
            wline <= line_wdata;
            cnt   <= '0;
            state <= WRITE;
          end
        end
        READ: begin
          if (burst_resp) begin
            rline[cnt] <= burst_rdata;
            cnt        <= cnt + 2'd1;
            if (last_beat) state <= DONE;
          end
        end
        WRITE: begin
          if (burst_resp) begin
            cnt <= cnt + 2'd1;
            if (last_beat) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign line_rdata    = rline;
  assign line_resp     = (state == DONE);
  assign burst_read    = (state == READ);
  assign burst_write   = (state == WRITE);
  assign burst_address = addr & 32'hFFFF_FFE0;
  assign burst_wdata   = wline[cnt];

`ifdef CACHELINE_ADAPTER_PERF_EN
  // Counted on the edge that enters DONE, so the new total is visible during line_resp.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_lines  <= '0;
      write_lines <= '0;
    end else begin
      if (state == READ && last_beat && read_lines != 32'hFFFF_FFFF)
        read_lines <= read_lines + 32'd1;
      if (state == WRITE && last_beat && write_lines != 32'hFFFF_FFFF)
        write_lines <= write_lines + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: directed vectors, a write-beat table and
// randomized transactions compared against a transaction-level reference model.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;
`ifdef CACHELINE_ADAPTER_PERF_EN
  logic [31:0]  read_lines;
  logic [31:0]  write_lines;
`endif

  cacheline_adapter dut (
    .clk           (clk),
    .rst           (rst),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_address  (line_address),
    .line_wdata    (line_wdata),
    .line_rdata    (line_rdata),
    .line_resp     (line_resp),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_address (burst_address),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
`ifdef CACHELINE_ADAPTER_PERF_EN
    ,
    .read_lines    (read_lines),
    .write_lines   (write_lines)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: last completed read line and completion counts since reset.
  logic [255:0] model_line;
  int           model_rd;
  int           model_wr;

  typedef struct {
    logic        resp;
    logic        bw;
    logic        chk_wd;
    logic [63:0] wd;
    logic        lr;
  } wvec_t;

  wvec_t wtab[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    line_read = 1'b0;
    line_write = 1'b0;
    burst_resp = 1'b0;
    step();
    step();
    rst = 1'b0;
    model_line = '0;
    model_rd = 0;
    model_wr = 0;
  endtask

  // Plays four back-to-back read beats of pattern (k+1)*0x1111.. and checks DONE.
  task automatic read_four(input logic [31:0] a, input string tag);
    logic [255:0] exp;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_burst_read"}, burst_read, 1'b1);
      chk({tag, "_addr"}, burst_address, {a[31:5], 5'b0});
      burst_resp = 1'b1;
      burst_rdata = 64'h1111_1111_1111_1111 * 64'(k + 1);
      exp[64*k +: 64] = burst_rdata;
      step();
    end
    burst_resp = 1'b0;
    chk({tag, "_line_resp"}, line_resp, 1'b1);
    chk({tag, "_rdata"}, line_rdata, exp);
    model_line = exp;
    model_rd++;
  endtask

  // One random transaction checked against the model.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] wd);
    logic [255:0] got;
    int k;
    int cyc;
    bit is_read;
    is_read = rd;
    for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
      burst_resp = 1'($urandom_range(0, 1));
      burst_rdata = {$urandom, $urandom};
      step();
      chk("rnd_idle_read", burst_read, 1'b0);
      chk("rnd_idle_rdata", line_rdata, model_line);
    end
    line_read = rd;
    line_write = wr;
    line_address = a;
    line_wdata = wd;
    burst_resp = 1'($urandom_range(0, 1));
    step();
    k = 0;
    cyc = 0;
    got = '0;
    while (k < 4) begin
      line_read = 1'($urandom_range(0, 1));
      line_write = 1'($urandom_range(0, 1));
      line_address = $urandom;
      line_wdata = {8{$urandom}};
      chk("rnd_burst_read", burst_read, is_read);
      chk("rnd_burst_write", burst_write, !is_read);
      chk("rnd_addr", burst_address, a & 32'hFFFF_FFE0);
      chk("rnd_no_resp", line_resp, 1'b0);
      if (!is_read) chk("rnd_wdata", burst_wdata, wd[64*k +: 64]);
      burst_resp = (cyc > 20) ? 1'b1 : 1'($urandom_range(0, 1));
      burst_rdata = {$urandom, $urandom};
      if (burst_resp) begin
        got[64*k +: 64] = burst_rdata;
        k++;
      end
      step();
      cyc++;
    end
    line_read = 1'b0;
    line_write = 1'b0;
    burst_resp = 1'($urandom_range(0, 1));
    burst_rdata = {$urandom, $urandom};
    if (is_read) begin
      model_line = got;
      model_rd++;
    end else begin
      model_wr++;
    end
    chk("rnd_done_resp", line_resp, 1'b1);
    chk("rnd_done_rdata", line_rdata, model_line);
    step();
    chk("rnd_after_resp", line_resp, 1'b0);
    chk("rnd_after_rdata", line_rdata, model_line);
    burst_resp = 1'b0;
  endtask

  initial begin
    logic [63:0]  d [4];
    logic [255:0] wl;
    line_address = '0;
    line_wdata = '0;
    burst_rdata = '0;
    do_reset();

    // Reset state
    chk("rst_line_resp", line_resp, 1'b0);
    chk("rst_burst_read", burst_read, 1'b0);
    chk("rst_burst_write", burst_write, 1'b0);
    chk("rst_rdata", line_rdata, '0);
    chk("rst_addr", burst_address, 32'h0);

    // Basic read of 0x1234
    line_read = 1'b1;
    line_address = 32'h0000_1234;
    step();
    line_read = 1'b0;
    chk("rd1_addr_abs", burst_address, 32'h0000_1220);
    read_four(32'h0000_1234, "rd1");
    chk("rd1_full", line_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    step();
    chk("rd1_idle_resp", line_resp, 1'b0);

    // Write with beats on cycles 2,5,6,9 of the burst
    d[0] = 64'h0123_4567_89AB_CDEF;
    d[1] = 64'hFEDC_BA98_7654_3210;
    d[2] = 64'hA5A5_5A5A_DEAD_BEEF;
    d[3] = 64'h0F0F_F0F0_CAFE_F00D;
    wl = {d[3], d[2], d[1], d[0]};
    wtab[0]  = '{1'b0, 1'b1, 1'b1, d[0], 1'b0};
    wtab[1]  = '{1'b0, 1'b1, 1'b1, d[0], 1'b0};
    wtab[2]  = '{1'b1, 1'b1, 1'b1, d[0], 1'b0};
    wtab[3]  = '{1'b0, 1'b1, 1'b1, d[1], 1'b0};
    wtab[4]  = '{1'b0, 1'b1, 1'b1, d[1], 1'b0};
    wtab[5]  = '{1'b1, 1'b1, 1'b1, d[1], 1'b0};
    wtab[6]  = '{1'b1, 1'b1, 1'b1, d[2], 1'b0};
    wtab[7]  = '{1'b0, 1'b1, 1'b1, d[3], 1'b0};
    wtab[8]  = '{1'b0, 1'b1, 1'b1, d[3], 1'b0};
    wtab[9]  = '{1'b1, 1'b1, 1'b1, d[3], 1'b0};
    wtab[10] = '{1'b0, 1'b0, 1'b0, 64'h0, 1'b1};
    wtab[11] = '{1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
    line_write = 1'b1;
    line_address = 32'h0000_8047;
    line_wdata = wl;
    step();
    line_write = 1'b0;
    line_wdata = '0;
    for (int i = 0; i < 12; i++) begin
      burst_resp = wtab[i].resp;
      chk($sformatf("wr_bw_%0d", i), burst_write, wtab[i].bw);
      chk($sformatf("wr_lr_%0d", i), line_resp, wtab[i].lr);
      if (wtab[i].chk_wd) chk($sformatf("wr_wd_%0d", i), burst_wdata, wtab[i].wd);
      if (wtab[i].bw) chk($sformatf("wr_addr_%0d", i), burst_address, 32'h0000_8040);
      step();
    end
    burst_resp = 1'b0;
    chk("wr_rdata_held", line_rdata, model_line);

    // Both requests high: read only
    line_read = 1'b1;
    line_write = 1'b1;
    line_address = 32'h0000_2000;
    line_wdata = {8{32'h5555_AAAA}};
    step();
    line_read = 1'b0;
    line_write = 1'b0;
    chk("both_no_write", burst_write, 1'b0);
    read_four(32'h0000_2000, "both");
    step();

    // Reset after two read beats
    line_read = 1'b1;
    line_address = 32'h0000_3000;
    step();
    line_read = 1'b0;
    for (int k = 0; k < 2; k++) begin
      burst_resp = 1'b1;
      burst_rdata = {2{$urandom}};
      step();
    end
    burst_resp = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_line = '0;
    model_rd = 0;
    model_wr = 0;
    chk("abort_burst_read", burst_read, 1'b0);
    chk("abort_line_resp", line_resp, 1'b0);
    chk("abort_rdata", line_rdata, '0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort_quiet_resp", line_resp, 1'b0);
      chk("abort_quiet_read", burst_read, 1'b0);
    end
    line_read = 1'b1;
    line_address = 32'h0000_3004;
    step();
    line_read = 1'b0;
    read_four(32'h0000_3004, "after_abort");
    step();

    // Back-to-back reads with request held through line_resp
    do_reset();
    line_read = 1'b1;
    line_address = 32'h0000_4000;
    step();
    read_four(32'h0000_4000, "b2b1");
    step();
    chk("b2b_gap_read", burst_read, 1'b0);
    chk("b2b_gap_resp", line_resp, 1'b0);
    step();
    chk("b2b_second_read", burst_read, 1'b1);
    read_four(32'h0000_4000, "b2b2");
    line_read = 1'b0;
`ifdef CACHELINE_ADAPTER_PERF_EN
    chk("b2b_read_lines", read_lines, 32'd2);
    chk("b2b_write_lines", write_lines, 32'd0);
`endif
    step();
    step();
    chk("b2b_idle_read", burst_read, 1'b0);

    // Randomized transactions
    do_reset();
    for (int t = 0; t < 40; t++) begin
      bit rd;
      bit wr;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(rd, wr, $urandom, {8{$urandom}});
    end
`ifdef CACHELINE_ADAPTER_PERF_EN
    chk("rnd_read_lines", read_lines, 32'(model_rd));
    chk("rnd_write_lines", write_lines, 32'(model_wr));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 Parameters SHALL be:
- s_line, 256, cache line width in bits.
- s_beat, 64, burst beat width in bits.
- Beats per line = s_line/s_beat = 4.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- line_read  in  1  cache requests line fill.
- line_write  in  1  cache requests line writeback.
- line_address  in  32  cache request address.
- line_wdata  in  256  writeback line.
- line_rdata  out  256  filled line.
- line_resp  out  1  request complete.
- burst_read  out  1  memory read burst request.
- burst_write  out  1  memory write burst request.
- burst_address  out  32  line-aligned burst address.
- burst_wdata  out  64  current write beat.
- burst_rdata  in  64  current read beat.
- burst_resp  in  1  beat accepted/valid.

Function
REQ-003 FSM states SHALL be IDLE, READ, WRITE, DONE.
REQ-004 IDLE SHALL behave as follows:
- line_read=1 -> capture address, go to READ.
- line_write=1 -> capture address and line_wdata, go to WRITE.
- Both high -> read wins.
REQ-005 burst_address SHALL be {captured line_address[31:5], 5'b0} and stable for the whole burst.
REQ-006 burst_read SHALL be 1 exactly while in READ; burst_write SHALL be 1 exactly while in WRITE.
REQ-007 Beat counter SHALL be 2 bits, cleared on entering READ/WRITE, and increment only on cycles with burst_resp=1.
REQ-008 READ: on each burst_resp, burst_rdata SHALL be written to line_rdata bits [64*cnt+63 : 64*cnt] (beat 0 is the least significant word).
REQ-009 WRITE: burst_wdata SHALL be captured-line bits [64*cnt+63 : 64*cnt], combinationally following cnt.
REQ-010 Beats may be non-consecutive; cycles with burst_resp=0 SHALL hold cnt and all data.
REQ-011 A burst_resp on beat cnt=3 SHALL transition to DONE; the counter wraps 3->0 and does not overflow.
REQ-012 DONE SHALL last exactly one cycle with line_resp=1, then return to IDLE.
REQ-013 Read latency SHALL be one cycle after the 4th burst_resp to line_resp=1.
REQ-014 line_rdata SHALL be valid in DONE and held until the next read's first beat.
REQ-015 line_read/line_write SHALL be sampled only in IDLE; changes during a burst SHALL be ignored.
REQ-016 The cache holds its request through line_resp. The IDLE cycle after DONE SHALL re-sample, so a back-to-back request starts at the earliest 2 cycles after line_resp.
REQ-017 burst_resp SHALL be ignored in IDLE and DONE.

Reset
REQ-018 rst=1 SHALL force state IDLE, cnt=0, line_rdata=0, captured line=0, captured address=0, and set line_resp, burst_read and burst_write to 0, effective the next cycle.
REQ-019 rst mid-burst SHALL abort the burst with no line_resp; rst has priority over all other inputs.

Configuration
REQ-020 With macro CACHELINE_ADAPTER_PERF_EN defined, the block SHALL add:
- Output ports read_lines (32) and write_lines (32), each incremented once per DONE of its type.
- Both saturate at 32'hFFFFFFFF and reset to 0.
REQ-021 Without CACHELINE_ADAPTER_PERF_EN, these ports and counters SHALL NOT exist and behaviour is otherwise identical.

Verification
REQ-022 The bench SHALL cover:
- Read, addr 0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. with burst_resp every cycle -> burst_address=0x0000_1220, line_resp one cycle after 4th beat, line_rdata={0x44..,0x33..,0x22..,0x11..}.
- Write, line_wdata={D3,D2,D1,D0}, burst_resp on cycles 2,5,6,9 -> burst_wdata D0,D1,D2,D3 at those beats, cnt held between, single line_resp.
- line_read and line_write both high in IDLE -> READ burst only, burst_write stays 0.
- rst asserted after 2 read beats -> next cycle IDLE, burst_read=0, no line_resp; new read completes normally.
- Back-to-back reads held high -> second burst_read rises 2 cycles after first line_resp; with PERF_EN, read_lines=2.
